dmem_arbiter: RTL

Two-port arbiter and sequencer in front of the byte-addressed data RAM. It shares the RAM between port 0 (CPU load/store path) and port 1 (loader/DMA path) and grants them round-robin. It registers each accepted request, drives the RAM size strobes (sb/sh/sw) for one cycle, and returns a registered response. Loads are zero- or sign-extended; accesses outside the RAM window or with an illegal size return an error.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_arbiter_rr_arb2.sv | 46 ++++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types, window constants and helpers for the data-RAM arbiter.
package dmem_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RAM_BASE = 32'h0000_1000;
  localparam logic [31:0] RAM_TOP  = 32'h0000_1FFF;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_t;

  // Illegal size reports 4 bytes; it is rejected separately anyway.
  function automatic logic [2:0] nbytes(size_t size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] ld_extend(logic [XLEN-1:0] data, size_t size, logic uns);
    case (size)
      SZ_B:    return {{(XLEN-8){~uns & data[7]}}, data[7:0]};
      SZ_H:    return {{(XLEN-16){~uns & data[15]}}, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant with a remembered last winner; port 0 wins the first tie.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_q, last_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        // Favour the port that did not win last time.
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of the byte-addressed data RAM.
module dmem_arbiter #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RAM_BASE = dmem_pkg::RAM_BASE,
  parameter logic [ADDR_W-1:0] RAM_TOP  = dmem_pkg::RAM_TOP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  output logic              gnt0,
  input  logic              we0,
  input  logic [1:0]        size0,
  input  logic              uns0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] wd0,
  output logic              rvalid0,
  output logic [ADDR_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  output logic              gnt1,
  input  logic              we1,
  input  logic [1:0]        size1,
  input  logic              uns1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] wd1,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] ram_a,
  output logic [ADDR_W-1:0] ram_wd,
  output logic              ram_sb,
  output logic              ram_sh,
  output logic              ram_sw,
  input  logic [ADDR_W-1:0] ram_rd
);

  import dmem_pkg::*;

  state_t state_q, state_d;

  logic              port_q, we_q, uns_q, err_q;
  size_t             size_q;
  logic [ADDR_W-1:0] addr_q, wd_q;

  logic              grant_en, hs;
  logic              sel_we, sel_uns, sel_err;
  size_t             sel_size;
  logic [ADDR_W-1:0] sel_addr, sel_wd;
  logic [ADDR_W:0]   end_addr;
  logic              store_en;
  logic [ADDR_W-1:0] resp_data;

  assign grant_en = (state_q != StAccess);
  assign hs       = (req0 & gnt0) | (req1 & gnt1);

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (grant_en),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_comb begin
    sel_we   = gnt1 ? we1 : we0;
    sel_uns  = gnt1 ? uns1 : uns0;
    sel_size = size_t'(gnt1 ? size1 : size0);
    sel_addr = gnt1 ? addr1 : addr0;
    sel_wd   = gnt1 ? wd1 : wd0;
    // One extra bit so an access running past the top of the address space is caught.
    end_addr = {1'b0, sel_addr} + {{(ADDR_W-2){1'b0}}, nbytes(sel_size)} - (ADDR_W+1)'(1);
    sel_err  = (sel_size == SZ_BAD) || (sel_addr < RAM_BASE) || (end_addr > {1'b0, RAM_TOP});
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (hs) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = hs ? StAccess : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Strobes are gated by rst_n so a reset edge never commits a write.
  always_comb begin
    store_en  = (state_q == StAccess) && we_q && !err_q && rst_n;
    ram_sb    = store_en && (size_q == SZ_B);
    ram_sh    = store_en && (size_q == SZ_H);
    ram_sw    = store_en && (size_q == SZ_W);
    ram_a     = (state_q == StAccess) ? addr_q : '0;
    ram_wd    = (state_q == StAccess) ? wd_q : '0;
    resp_data = (we_q || err_q) ? '0 : ld_extend(ram_rd, size_q, uns_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wd_q    <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state_q <= state_d;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (hs) begin
        port_q <= gnt1;
        we_q   <= sel_we;
        uns_q  <= sel_uns;
        err_q  <= sel_err;
        size_q <= sel_size;
        addr_q <= sel_addr;
        wd_q   <= sel_wd;
      end
      if (state_q == StAccess) begin
        if (port_q) begin
          rvalid1 <= 1'b1;
          err1    <= err_q;
          rdata1  <= resp_data;
        end else begin
          rvalid0 <= 1'b1;
          err0    <= err_q;
          rdata0  <= resp_data;
        end
      end
    end
  end

endmodule
